// File: rtl/timer_pkg.sv
// Shared BCD constants and helpers for the MM:SS tick timer.
// Provides the digit widths and the per-digit range check used on loads.
package timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam int DIGITS_N = 4;
    localparam int DIGITS_W = BCD_W * DIGITS_N;

    function automatic logic bcd_valid(
        input logic [BCD_W-1:0] digit,
        input logic [BCD_W-1:0] max
    );
        return digit <= max;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronises an asynchronous level into inclk and emits a registered
// one-cycle pulse on each rising edge. Ports: inclk, rst_n, async_in, pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic inclk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/tick_bcd_timer.sv
// BCD MM:SS stopwatch / countdown driven by synchronised slow_clk ticks.
// In: inclk rst_n slow_clk run dir clear load load_val; out: digits tick wrap done load_err.
module tick_bcd_timer
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_TENS    = 5
) (
    input  logic                inclk,
    input  logic                rst_n,
    input  logic                slow_clk,
    input  logic                run,
    input  logic                dir,
    input  logic                clear,
    input  logic                load,
    input  logic [DIGITS_W-1:0] load_val,
    output logic [DIGITS_W-1:0] digits,
    output logic                tick,
    output logic                wrap,
    output logic                done,
    output logic                load_err
);

    localparam logic [BCD_W-1:0] TMAX = BCD_W'(MAX_TENS);

    logic tick_w;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .inclk   (inclk),
        .rst_n   (rst_n),
        .async_in(slow_clk),
        .pulse   (tick_w)
    );

    logic [BCD_W-1:0] su_q, st_q, mu_q, mt_q;
    logic [BCD_W-1:0] su_d, st_d, mu_d, mt_d;
    logic             wrap_q, done_q, err_q;
    logic             wrap_d, done_d, err_d;
    logic             ld_ok, step, is_zero, is_one;

    always_comb begin
        su_d   = su_q;
        st_d   = st_q;
        mu_d   = mu_q;
        mt_d   = mt_q;
        wrap_d = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;

        ld_ok = bcd_valid(load_val[3:0], BCD_MAX)
             && bcd_valid(load_val[7:4], TMAX)
             && bcd_valid(load_val[11:8], BCD_MAX)
             && bcd_valid(load_val[15:12], TMAX);
        step    = tick_w & run;
        is_zero = {mt_q, mu_q, st_q, su_q} == '0;
        is_one  = {mt_q, mu_q, st_q} == '0 && su_q == 4'd1;

        if (clear) begin
            su_d = '0;
            st_d = '0;
            mu_d = '0;
            mt_d = '0;
        end else if (load && ld_ok) begin
            {mt_d, mu_d, st_d, su_d} = load_val;
        end else begin
            // A rejected load still lets a coincident tick count.
            err_d = load;
            if (step && !dir) begin
                if (su_q == BCD_MAX) begin
                    su_d = '0;
                    if (st_q == TMAX) begin
                        st_d = '0;
                        if (mu_q == BCD_MAX) begin
                            mu_d = '0;
                            if (mt_q == TMAX) begin
                                mt_d   = '0;
                                wrap_d = 1'b1;
                            end else begin
                                mt_d = mt_q + 4'd1;
                            end
                        end else begin
                            mu_d = mu_q + 4'd1;
                        end
                    end else begin
                        st_d = st_q + 4'd1;
                    end
                end else begin
                    su_d = su_q + 4'd1;
                end
            end else if (step && dir && !is_zero) begin
                // Non-zero guarantees some higher digit can lend.
                done_d = is_one;
                if (su_q == '0) begin
                    su_d = BCD_MAX;
                    if (st_q == '0) begin
                        st_d = TMAX;
                        if (mu_q == '0) begin
                            mu_d = BCD_MAX;
                            mt_d = mt_q - 4'd1;
                        end else begin
                            mu_d = mu_q - 4'd1;
                        end
                    end else begin
                        st_d = st_q - 4'd1;
                    end
                end else begin
                    su_d = su_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            su_q   <= '0;
            st_q   <= '0;
            mu_q   <= '0;
            mt_q   <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            su_q   <= su_d;
            st_q   <= st_d;
            mu_q   <= mu_d;
            mt_q   <= mt_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign digits   = {mt_q, mu_q, st_q, su_q};
    assign tick     = tick_w;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign load_err = err_q;

endmodule
